// File: rtl/audio_sample_player_pkg.sv
// Shared widths, default sample-period divider and FSM state encoding for the audio player.
// The ROM-side blocks use the same width constants so address/data buses always line up.
package audio_sample_player_pkg;

  localparam int AUDIO_ADDR_W  = 14;
  localparam int AUDIO_DATA_W  = 16;
  localparam int AUDIO_CLK_DIV = 1250;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/audio_tick_gen.sv
// Sample-period divider: counts 0..CLK_DIV-1 while enabled and flags the last count.
// Held at zero when disabled or cleared, so a new period always starts from a full count.
module audio_tick_gen
  import audio_sample_player_pkg::*;
#(
  parameter int CLK_DIV = AUDIO_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == CNT_W'(CLK_DIV - 1));

  // NOTE: registered state uses non-blocking assignments only; combinational blocks use blocking.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/audio_sample_player.sv
// Sample-rate sequencer: walks a start..end window of the audio ROM one address per period,
// scales each word by the volume shift and emits one registered signed sample per period.
module audio_sample_player
  import audio_sample_player_pkg::*;
#(
  parameter int ADDR_W  = AUDIO_ADDR_W,
  parameter int DATA_W  = AUDIO_DATA_W,
  parameter int CLK_DIV = AUDIO_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [1:0]        volume,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              tick;
  logic signed [DATA_W-1:0] rom_s;
  logic signed [DATA_W-1:0] scaled;

  audio_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (start || stop),
    .en_i   (state_q != ST_IDLE),
    .tick_o (tick)
  );

  // Volume 3 passes the word through; each step down adds one sign-preserving halving.
  assign rom_s  = rom_data;
  assign scaled = rom_s >>> (2'd3 - volume);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    first_d  = first_q;
    last_d   = last_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    if (stop) begin
      state_d  = ST_IDLE;
      sample_d = '0;
    end else if (start) begin
      first_d = start_addr;
      last_d  = end_addr;
      addr_d  = start_addr;
      state_d = ST_PLAY;
    end else if (tick) begin
      case (state_q)
        ST_PLAY: begin
          sample_d = scaled;
          valid_d  = 1'b1;
          if (addr_q != last_q) begin
            addr_d = addr_q + ADDR_W'(1);
          end else if (loop_en) begin
            addr_d = first_q;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          sample_d = '0;
          valid_d  = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      first_q  <= '0;
      last_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      first_q  <= first_d;
      last_q   <= last_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign rom_addr     = addr_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_audio_sample_player.sv
// Self-checking bench for audio_sample_player: a period-countdown reference model compared
// every cycle, plus directed scenarios with hand-computed sample sequences and timings.
module tb_audio_sample_player;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 16384;

  logic        clk = 1'b0;
  logic        rst, start, stop, loop_en;
  logic [13:0] start_addr, end_addr, rom_addr;
  logic [1:0]  volume;
  logic [15:0] rom_data, sample_out;
  logic        sample_valid, busy, done;

  logic        rom_force = 1'b0;
  logic [15:0] rom_val   = 16'h0000;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  audio_sample_player #(.CLK_DIV(CLK_DIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .loop_en      (loop_en),
    .start_addr   (start_addr),
    .end_addr     (end_addr),
    .volume       (volume),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done)
  );

  // ROM model: word a holds a*16 unless a forced value is being injected.
  assign rom_data = rom_force ? rom_val : {rom_addr, 4'b0000};

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int rom_ref(input int a);
    int v;
    v = rom_force ? int'(rom_val) : ((a * 16) & 16'hFFFF);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  // Arithmetic right shift as floor division by a power of two.
  function automatic int shift_ref(input int x, input int sh);
    int d;
    d = 1 << sh;
    return (x >= 0) ? x / d : -((-x + d - 1) / d);
  endfunction

  // Reference model: playing/draining flags plus a countdown of edges to the next sample.
  bit m_ok = 0, m_play = 0, m_drain = 0, m_valid = 0, m_done = 0;
  int m_addr = 0, m_first = 0, m_last = 0, m_left = 0, m_sample = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_ok = 1; m_play = 0; m_drain = 0; m_valid = 0; m_done = 0;
      m_addr = 0; m_sample = 0; m_left = 0;
    end else begin
      m_valid = 0;
      m_done  = 0;
      if (stop) begin
        m_play = 0; m_drain = 0; m_sample = 0;
      end else if (start) begin
        m_first = int'(start_addr); m_last = int'(end_addr); m_addr = int'(start_addr);
        m_play = 1; m_drain = 0; m_left = CLK_DIV;
      end else if (m_play || m_drain) begin
        m_left--;
        if (m_left == 0) begin
          m_left  = CLK_DIV;
          m_valid = 1;
          if (m_play) begin
            m_sample = shift_ref(rom_ref(m_addr), 3 - int'(volume));
            if (m_addr != m_last)  m_addr = (m_addr + 1) % DEPTH;
            else if (loop_en)      m_addr = m_first;
            else begin m_play = 0; m_drain = 1; end
          end else begin
            m_sample = 0; m_done = 1; m_drain = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("cmp rom_addr", int'(rom_addr), m_addr);
      check("cmp sample_out", int'($signed(sample_out)), m_sample);
      check("cmp sample_valid", int'(sample_valid), int'(m_valid));
      check("cmp busy", int'(busy), int'(m_play || m_drain));
      check("cmp done", int'(done), int'(m_done));
    end
  end

  // Log of emitted samples, their cycle stamps and done pulses for the directed checks.
  int vq[$];
  int tq[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (sample_valid) begin
      vq.push_back(int'($signed(sample_out)));
      tq.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  int t0;

  task automatic clear_log();
    vq.delete();
    tq.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input int sa, input int ea, input bit lp, input int vol);
    start = 1'b1; start_addr = 14'(sa); end_addr = 14'(ea); loop_en = lp; volume = 2'(vol);
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_valid && n < budget);
    check("sample_valid seen", int'(sample_valid), 1);
  endtask

  task automatic check_log(input string name, input int exp_v[], input int first_at);
    check({name, " count"}, vq.size(), exp_v.size());
    for (int i = 0; i < exp_v.size() && i < vq.size(); i++) begin
      check($sformatf("%s value[%0d]", name, i), vq[i], exp_v[i]);
      check($sformatf("%s time[%0d]", name, i), tq[i], first_at + CLK_DIV * i);
    end
  endtask

  initial begin
    int t1;
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    start_addr = '0; end_addr = '0; volume = 2'd3;
    repeat (3) @(negedge clk);
    check("reset rom_addr", int'(rom_addr), 0);
    check("reset sample_out", int'(sample_out), 0);
    check("reset busy", int'(busy), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // One-shot 10..12 at full volume.
    clear_log();
    do_start(10, 12, 1'b0, 3);
    repeat (19) @(negedge clk);
    check_log("oneshot", '{160, 176, 192, 0}, t0 + 4);
    check("oneshot done pulses", done_cnt, 1);
    check("oneshot busy after", int'(busy), 0);

    // Looped 5..6, then stop.
    clear_log();
    do_start(5, 6, 1'b1, 3);
    repeat (21) @(negedge clk);
    check_log("loop", '{80, 96, 80, 96, 80}, t0 + 4);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("loop stop sample_out", int'(sample_out), 0);
    check("loop stop busy", int'(busy), 0);
    check("loop done pulses", done_cnt, 0);

    // Window wrapping through the top of the address space.
    clear_log();
    do_start(16383, 1, 1'b0, 3);
    check("wrap first rom_addr", int'(rom_addr), 16383);
    repeat (18) @(negedge clk);
    check_log("wrap", '{-16, 0, 16, 0}, t0 + 4);
    check("wrap done pulses", done_cnt, 1);

    // Volume shifts on injected extreme words.
    clear_log();
    rom_force = 1'b1; rom_val = 16'h8000;
    do_start(0, 0, 1'b1, 0);
    wait_valid(10);
    check("vol0 of 0x8000", int'(sample_out), 16'hF000);
    volume = 2'd2;
    wait_valid(10);
    check("vol2 of 0x8000", int'(sample_out), 16'hC000);
    rom_val = 16'h7FF0; volume = 2'd1;
    wait_valid(10);
    check("vol1 of 0x7FF0", int'(sample_out), 16'h1FFC);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; rom_force = 1'b0; volume = 2'd3;

    // Start+stop collision during play, then restart at divider 2.
    clear_log();
    do_start(20, 30, 1'b0, 3);
    wait_valid(10);
    check("collide first sample", int'(sample_out), 320);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("collide busy", int'(busy), 0);
    check("collide sample_out", int'(sample_out), 0);
    do_start(40, 50, 1'b0, 3);
    repeat (2) @(negedge clk);
    start = 1'b1; start_addr = 14'd100; end_addr = 14'd101;
    t1 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(10);
    check("restart sample", int'(sample_out), 1600);
    check("restart timing", cyc, t1 + 4);
    check("collide done pulses", done_cnt, 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

    // Reset on the edge where a tick is due.
    do_start(200, 210, 1'b0, 3);
    wait_valid(10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset sample_valid", int'(sample_valid), 0);
    check("midreset busy", int'(busy), 0);
    check("midreset sample_out", int'(sample_out), 0);
    check("midreset rom_addr", int'(rom_addr), 0);
    check("midreset done", int'(done), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
